// File: rtl/manager_fsm_buf.sv
// -----------------------------------------------------------------------------
// manager_fsm_buf
//
// Record manager between the RS serial receiver and the flash writer. A packet
// of PKT_LEN received bytes is collected into a small buffer, then written to
// consecutive flash addresses one byte at a time. Each flash write is a
// one-cycle FL_WE pulse followed by a wait for FL_STATUS, with a per-attempt
// timeout and a bounded number of re-issued attempts before giving up.
//
// Ports:
//   CLK_50MHZ  in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   RS_DONE    in   one-cycle strobe, RS_DATA valid
//   RS_DATA    in   received byte
//   FL_STATUS  in   flash write-complete acknowledge
//   FL_WE      out  flash write request (one-cycle pulse)
//   FL_ADDR    out  flash write address
//   FL_DATA    out  flash write data
//   BUSY       out  high while a record is being written
//   DONE       out  high in STOP
//   ERROR      out  high in ERROR (terminal until reset)
//   OVERRUN    out  sticky, an RS byte arrived when it could not be stored
//   REC_CNT    out  completed records, wraps
//   STATE      out  current state encoding (debug)
// -----------------------------------------------------------------------------
module manager_fsm_buf #(
    parameter int DATA_W     = 8,
    parameter int PKT_LEN    = 4,
    parameter int ADDR_W     = 22,
    parameter int TIMEOUT    = 1024,
    parameter int MAX_RETRY  = 3,
    parameter int CONTINUOUS = 0,
    parameter int CNT_W      = 16
) (
    input  logic              CLK_50MHZ,
    input  logic              RST_N,
    input  logic              RS_DONE,
    input  logic [DATA_W-1:0] RS_DATA,
    input  logic              FL_STATUS,
    output logic              FL_WE,
    output logic [ADDR_W-1:0] FL_ADDR,
    output logic [DATA_W-1:0] FL_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERROR,
    output logic              OVERRUN,
    output logic [CNT_W-1:0]  REC_CNT,
    output logic [2:0]        STATE
);

    localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAITING_RS = 3'd1,
        S_READING_RS = 3'd2,
        S_WRITING_FL = 3'd3,
        S_WAITING_FL = 3'd4,
        S_STOP       = 3'd5,
        S_ERROR      = 3'd6
    } state_t;

    state_t              state_q,   state_d;
    logic [IDX_W-1:0]    wr_idx_q,  wr_idx_d;
    logic [IDX_W-1:0]    rd_idx_q,  rd_idx_d;
    logic [RTY_W-1:0]    retry_q,   retry_d;
    logic [TMR_W-1:0]    timer_q,   timer_d;
    logic [ADDR_W-1:0]   fl_addr_q, fl_addr_d;
    logic [DATA_W-1:0]   fl_data_q, fl_data_d;
    logic [CNT_W-1:0]    rec_cnt_q, rec_cnt_d;
    logic                overrun_q, overrun_d;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [PKT_LEN];

    // State register and datapath registers
    always_ff @(posedge CLK_50MHZ or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            retry_q   <= '0;
            timer_q   <= '0;
            fl_addr_q <= '0;
            fl_data_q <= '0;
            rec_cnt_q <= '0;
            overrun_q <= 1'b0;
            for (int i = 0; i < PKT_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            retry_q   <= retry_d;
            timer_q   <= timer_d;
            fl_addr_q <= fl_addr_d;
            fl_data_q <= fl_data_d;
            rec_cnt_q <= rec_cnt_d;
            overrun_q <= overrun_d;
            if (mem_we) begin
                mem_q[wr_idx_q] <= RS_DATA;
            end
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d   = state_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        retry_d   = retry_q;
        timer_d   = timer_q;
        fl_addr_d = fl_addr_q;
        fl_data_d = fl_data_q;
        rec_cnt_d = rec_cnt_q;
        overrun_d = overrun_q;
        mem_we    = 1'b0;

        // Bytes can only be accepted while collecting; anything else is lost.
        if (RS_DONE && (state_q != S_WAITING_RS)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                wr_idx_d = '0;
                rd_idx_d = '0;
                retry_d  = '0;
                state_d  = S_WAITING_RS;
            end

            S_WAITING_RS: begin
                if (RS_DONE) begin
                    mem_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        rd_idx_d = '0;
                        state_d  = S_READING_RS;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                end
            end

            S_READING_RS: begin
                fl_data_d = mem_q[rd_idx_q];
                timer_d   = '0;
                state_d   = S_WRITING_FL;
            end

            S_WRITING_FL: begin
                timer_d = '0;
                state_d = S_WAITING_FL;
            end

            S_WAITING_FL: begin
                timer_d = timer_q + TMR_W'(1);
                // The acknowledge takes priority over a coincident timeout.
                if (FL_STATUS) begin
                    fl_addr_d = fl_addr_q + ADDR_W'(1);
                    retry_d   = '0;
                    if (rd_idx_q == LAST_IDX) begin
                        rec_cnt_d = rec_cnt_q + CNT_W'(1);
                        state_d   = (CONTINUOUS != 0) ? S_WAITING_RS : S_STOP;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                        state_d  = S_READING_RS;
                    end
                end else if (timer_q == TMR_LAST) begin
                    // Re-issue with the same address and data still latched.
                    if (retry_q < RTY_MAX) begin
                        retry_d = retry_q + RTY_W'(1);
                        state_d = S_WRITING_FL;
                    end else begin
                        state_d = S_ERROR;
                    end
                end
            end

            S_STOP:  state_d = S_STOP;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase
    end

    // All outputs come from registers or decode of the state register.
    assign FL_WE   = (state_q == S_WRITING_FL);
    assign FL_ADDR = fl_addr_q;
    assign FL_DATA = fl_data_q;
    assign BUSY    = (state_q == S_READING_RS) || (state_q == S_WRITING_FL) ||
                     (state_q == S_WAITING_FL);
    assign DONE    = (state_q == S_STOP);
    assign ERROR   = (state_q == S_ERROR);
    assign OVERRUN = overrun_q;
    assign REC_CNT = rec_cnt_q;
    assign STATE   = state_q;

endmodule

// File: doc/manager_fsm_buf.md
# manager_fsm_buf

Parametrised record manager between the RS (serial) receiver and the flash writer. It collects a fixed-length packet of RS bytes into an internal buffer, then writes the packet byte by byte to consecutive flash addresses. Each write uses a request/acknowledge handshake with timeout and bounded retry. It supports one-shot or continuous recording and reports status, record count and error/overrun flags to the top level.

## Interface
- DATA_W, 8, width of RS byte and flash data word
- PKT_LEN, 4, bytes per record (≥1)
- ADDR_W, 22, flash address width
- TIMEOUT, 1024, cycles to wait for FL_STATUS per write attempt (≥2)
- MAX_RETRY, 3, re-issued write attempts before ERROR
- CONTINUOUS, 0, 0 = one record then STOP; 1 = loop forever
- CNT_W, 16, width of record counter

Ports:
- CLK_50MHZ  in  1  system clock, all logic on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- RS_DONE  in  1  one-cycle strobe: RS_DATA valid
- RS_DATA  in  DATA_W  received byte
- FL_STATUS  in  1  flash write-complete acknowledge (level or pulse)
- FL_WE  out  1  flash write request, one-cycle pulse
- FL_ADDR  out  ADDR_W  flash write address
- FL_DATA  out  DATA_W  flash write data
- BUSY  out  1  high outside IDLE/WAITING_RS/STOP/ERROR
- DONE  out  1  high in STOP
- ERROR  out  1  high in ERROR (sticky until reset)
- OVERRUN  out  1  sticky: RS byte dropped
- REC_CNT  out  CNT_W  completed records, wraps modulo 2^CNT_W
- STATE  out  3  current state encoding (debug)

## Operation
- States and encodings: IDLE=0, WAITING_RS=1, READING_RS=2, WRITING_FL=3, WAITING_FL=4, STOP=5, ERROR=6.
- Reset values: state IDLE. All outputs 0. Internal wr_idx, rd_idx, retry, timer and buffer are 0.
- IDLE: clears wr_idx, rd_idx and retry. Moves to WAITING_RS unconditionally after one cycle.
- WAITING_RS: on RS_DONE, stores RS_DATA into buf[wr_idx] and increments wr_idx.
  - If the stored byte is index PKT_LEN-1, wr_idx returns to 0, rd_idx is set to 0 and the next state is READING_RS.
- READING_RS: latches FL_DATA <= buf[rd_idx] and clears timer. Next state is WRITING_FL.
- WRITING_FL: FL_WE=1 for exactly this cycle, with FL_ADDR/FL_DATA stable. Next state is WAITING_FL and timer is cleared.
- WAITING_FL: timer increments each cycle. FL_STATUS is sampled only in this state.
  - On FL_STATUS: FL_ADDR increments, wrapping modulo 2^ADDR_W, and retry clears.
    - If rd_idx was PKT_LEN-1, REC_CNT increments and the next state is WAITING_RS when CONTINUOUS=1, otherwise STOP.
    - Otherwise rd_idx increments and the next state is READING_RS.
  - On timer==TIMEOUT-1 without FL_STATUS: if retry<MAX_RETRY, retry increments and the next state is WRITING_FL (same address and data). Otherwise the next state is ERROR.
  - FL_STATUS and timeout in the same cycle: the acknowledge wins.
- STOP, ERROR: terminal states, left only by RST_N.
- RS_DONE in any state other than WAITING_RS: the byte is discarded and OVERRUN is set. OVERRUN also sets in STOP and ERROR.
- The buffer is never read and written in the same state, so no bypass path is needed.
- FL_ADDR/FL_DATA hold their values outside the write states. FL_ADDR is not reset by IDLE, only by RST_N.
- Reset assertion mid-operation aborts immediately. FL_WE drops asynchronously, and a partial record is lost.

## Timing
- The last RS_DONE at cycle t gives READING_RS at t+1 and an FL_WE pulse at t+2.
- FL_STATUS seen in WAITING_FL at cycle a: the next byte's FL_WE is at a+2 (READING_RS at a+1).
- Minimum record write time is PKT_LEN×3 cycles with an immediate ack.
- Max time per byte before ERROR is (MAX_RETRY+1)×(TIMEOUT+1) cycles.
- All outputs are registered or decoded from the state register. There are no combinational paths from inputs to outputs.
- STATE/DONE/ERROR/BUSY change on the clock edge that enters the state.

## Test plan
- Reset, then 4 RS_DONE strobes with 0x11, 0x22, 0x33, 0x44 and FL_STATUS returned 1 cycle after each FL_WE -> 4 FL_WE pulses at addresses 0..3 with those data, then REC_CNT=1, DONE=1, STATE=5.
- CONTINUOUS=1, 3 packets of 4 bytes -> 12 writes at addresses 0..11, REC_CNT=3, STATE back at 1 after each record.
- TIMEOUT=8, MAX_RETRY=2, FL_STATUS never asserted -> 3 FL_WE pulses 9 cycles apart with the same address/data, then ERROR=1, STATE=6.
- First attempt times out, ack arrives on the second -> exactly 2 FL_WE pulses for byte 0, address advances by 1, retry cleared for byte 1.
- RS_DONE pulsed during WAITING_FL -> byte dropped, OVERRUN=1, flash data sequence unchanged.
- RST_N low for 1 cycle mid WAITING_FL -> all outputs 0, STATE=0, FL_ADDR=0. A new packet then writes from address 0.
